// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;
    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {pc, instr} pairs between the memory and decode.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int W = 2 * XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] ent0, ent1;
    logic         do_pop, do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = ent0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_data;
                    else               ent1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push keeps the occupancy unchanged.
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, memory issue and output buffering.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               N        = 1024,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            imem_re,
    output logic [XLEN-1:0] imem_a,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            err_misaligned
);
    localparam logic [XLEN-1:0] SPACE = XLEN'(ILEN_BYTES * N);

    state_e            state;
    logic [XLEN-1:0]   pc, inflight_pc;
    logic              inflight;
    logic [1:0]        buf_count;
    logic [2*XLEN-1:0] head;
    logic              xfer, issue;
    logic [2:0]        occ;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] p);
        return (p >= SPACE - XLEN'(ILEN_BYTES)) ? '0 : p + XLEN'(ILEN_BYTES);
    endfunction

    function automatic logic [XLEN-1:0] align_wrap(input logic [XLEN-1:0] p);
        return {p[XLEN-1:2], 2'b00} % SPACE;
    endfunction

    assign out_valid = (buf_count != 2'd0);
    assign xfer      = out_valid & out_ready;
    // Occupancy the buffer will have after this edge, counting the word in flight.
    assign occ       = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, xfer};
    assign issue     = (state == RUN) && (occ < 3'd2) && !redirect_valid;
    assign imem_re   = issue;
    assign imem_a    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            err_misaligned <= 1'b0;
        end else begin
            state <= en ? RUN : IDLE;
            if (redirect_valid) begin
                pc       <= align_wrap(redirect_pc);
                inflight <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) err_misaligned <= 1'b1;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= next_pc(pc);
                    inflight_pc <= pc;
                end
            end
        end
    end

    fetch_buf #(.W(2 * XLEN)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight & ~redirect_valid),
        .push_data ({inflight_pc, imem_rd}),
        .pop       (xfer),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head      (head)
    );

    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: N, 1024, instruction capacity of the instruction memory in words; the byte space is 4*N.
REQ-002 Parameter: RESET_PC, 32'h0, PC loaded at reset; SHALL be 4-byte aligned and < 4*N.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 en  in  1  fetch enable; low halts new memory issues.
REQ-006 imem_re  out  1  read enable to the instruction memory; data returns one cycle later.
REQ-007 imem_a  out  32  byte address to the instruction memory.
REQ-008 imem_rd  in  32  instruction word, valid the cycle after imem_re was high.
REQ-009 redirect_valid  in  1  single-cycle request to change the PC (branch, jump or trap).
REQ-010 redirect_pc  in  32  new PC, sampled when redirect_valid is high.
REQ-011 out_valid  out  1  the instruction and PC outputs are valid.
REQ-012 out_ready  in  1  the decode stage accepts the output; a transfer occurs when out_valid and out_ready are both high.
REQ-013 out_instr  out  32  fetched instruction.
REQ-014 out_pc  out  32  byte address of out_instr.
REQ-015 err_misaligned  out  1  sticky flag; set by a redirect with redirect_pc[1:0] != 0.

Function
REQ-016 States: IDLE (no issue) and RUN (issuing); IDLE->RUN when en=1; RUN->IDLE when en=0.
REQ-017 Issue condition: state RUN and (buf_count + inflight - xfer) < 2, where xfer = out_valid & out_ready; imem_re SHALL equal the issue condition combinationally.
REQ-018 imem_a SHALL equal pc; on each issue, pc <= (pc + 4) mod 4*N, so pc wraps from 4*N-4 to 0.
REQ-019 inflight SHALL be set on the edge of an issue and cleared on the following edge unless there is a new issue; an in-flight word is written to the buffer at that edge together with its pc.
REQ-020 Buffer: 2-entry FIFO of {pc, instr}; out_valid = (buf_count != 0); the outputs SHALL show the head entry; head is popped on xfer.
REQ-021 Latency: first imem_re in cycle k -> out_valid high in cycle k+2; sustained throughput 1 instruction/cycle while out_ready=1.
REQ-022 Stall: while out_ready=0 with the buffer full, imem_re=0; out_instr and out_pc SHALL stay stable; no instruction is lost or duplicated.
REQ-023 Redirect (any state): at the edge, the buffer is flushed, the in-flight word is discarded, pc <= {redirect_pc[31:2],2'b00} mod 4*N, and out_valid=0 in the next cycle.
REQ-024 Redirect together with xfer in the same cycle: the transfer is counted as completed; the flush then applies.
REQ-025 Redirect together with an issue in the same cycle: the issue is suppressed (imem_re=0 in that cycle).
REQ-026 A misaligned redirect SHALL set err_misaligned, which stays 1 until reset; the fetch continues from the aligned address.
REQ-027 en=0 with a word in flight: the word still completes into the buffer; the buffer keeps draining normally.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state=IDLE, pc=RESET_PC, inflight=0, buf_count=0, out_valid=0, err_misaligned=0.
REQ-029 While in reset, imem_re SHALL be 0; out_instr and out_pc reset to 0.
REQ-030 Reset mid-operation SHALL discard all buffered and in-flight words; after release, fetch restarts at RESET_PC.

Structure
REQ-031 Shared package fetch_pkg SHALL hold XLEN=32, ILEN_BYTES=4, and the state enum {IDLE, RUN}.
REQ-032 The buffer SHALL be the sub-module fetch_buf (2-entry FIFO, payload 64 bits, with push, pop, flush and count); all other logic stays in fetch_ctrl.

Verification
REQ-033 Reset release, en=1, out_ready=1, memory word i = 32'h1000_0000+i -> out_pc 0,4,8,... with matching words, first out_valid 2 cycles after the first imem_re, one per cycle.
REQ-034 out_ready=0 for 5 cycles mid-stream -> buffer holds 2, imem_re=0, outputs stable; on release, the sequence continues with no gap or duplicate.
REQ-035 redirect_valid with redirect_pc=32'h40 while in flight, with out_ready=1 -> next out_pc=32'h40, no stale word delivered; also repeat in the same cycle as a xfer.
REQ-036 N=16, run past the end of memory -> out_pc sequence ...,32'h38,32'h3C,32'h0,32'h4.
REQ-037 redirect_pc=32'h22 -> err_misaligned=1 (sticky), next out_pc=32'h20.
REQ-038 rst_n asserted with the buffer full and a word in flight -> out_valid=0 at once; after release, the first out_pc=RESET_PC.
